muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the Execute stage, beside the ALU and branch unit. It accepts an M-extension operation with its two forwarded source operands and runs a 32-iteration shift-add multiply or restoring divide. It returns the 32-bit result on a one-cycle done strobe. The hazard unit stalls Fetch/Decode/Execute while an M-op in Execute is not done.

---
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Uses 32-step shift-add multiply and restoring divide, with 1-cycle special cases for divide.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            flushE,
  output logic            busyE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE
);

  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d, done_q, done_d;

  // Operand decode, evaluated on the live inputs at the start edge
  logic            signed_a, signed_b, in_neg_a, in_neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    signed_a    = !(funct3E == 3'b011 || (funct3E[2] && funct3E[0]));
    signed_b    = signed_a && (funct3E != 3'b010);
    in_neg_a    = signed_a && SrcAE[XLEN-1];
    in_neg_b    = signed_b && SrcBE[XLEN-1];
    mag_a       = in_neg_a ? -SrcAE : SrcAE;
    mag_b       = in_neg_b ? -SrcBE : SrcBE;
    div_zero    = funct3E[2] && (SrcBE == '0);
    div_ovf     = funct3E[2] && !funct3E[0] && (SrcAE == MIN_NEG) && (SrcBE == '1);
    special_res = funct3E[1] ? (div_zero ? SrcAE : '0) : (div_zero ? '1 : MIN_NEG);
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, quotient/dividend}
  logic [XLEN:0]   mul_sum;
  logic            div_ge;
  logic [DW-1:0]   step;

  always_comb begin
    mul_sum = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_ge  = acc_q[DW-1:XLEN-1] >= {1'b0, b_q};
    if (op_q[2]) begin
      step = div_ge ? {acc_q[DW-2:XLEN-1] - b_q, acc_q[XLEN-2:0], 1'b1}
                    : {acc_q[DW-2:0], 1'b0};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up of the completed accumulator
  logic [DW-1:0]   prod;
  logic [XLEN-1:0] quo, rem, final_res;

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -step : step;
    quo  = (neg_a_q ^ neg_b_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem  = neg_a_q ? -step[DW-1:XLEN] : step[DW-1:XLEN];
    if (op_q[2]) begin
      final_res = op_q[1] ? rem : quo;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[DW-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (startE) begin
          op_d    = funct3E;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          b_d     = mag_b;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          cnt_d   = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = ITER;
          end
        end
      end
      ITER: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything but reset; the old result is kept
    if (flushE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end

    busy_d = (state_d == ITER);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busyE   = busy_q;
  assign doneE   = done_q;
  assign resultE = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a cycle-count model with 64-bit reference arithmetic, checked every cycle.
// It also runs directed vectors with literal expectations plus randomized back-to-back traffic.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startE = 1'b0;
  logic        flushE = 1'b0;
  logic [2:0]  funct3E = 3'd0;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        busyE, doneE;
  logic [31:0] resultE;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .startE(startE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .flushE(flushE),
    .busyE(busyE), .doneE(doneE), .resultE(resultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model: cycles since the start edge; done on cycle m_lat, busy before it
  int          m_cyc = 0;
  int          m_lat = 0;
  logic [31:0] m_val = 32'd0;
  logic [31:0] exp_res = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc   = 0;
      exp_res = 32'd0;
    end else if (flushE) begin
      m_cyc = 0;
    end else if (m_cyc == 0) begin
      if (startE) begin
        m_lat = is_special(funct3E, SrcAE, SrcBE) ? 1 : 33;
        m_val = ref_model(funct3E, SrcAE, SrcBE);
        m_cyc = 1;
        if (m_lat == 1) exp_res = m_val;
      end
    end else if (m_cyc == m_lat) begin
      m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_cyc == m_lat) exp_res = m_val;
    end
  end

  always @(negedge clk) begin
    check("cyc busyE", 32'(busyE), 32'(m_cyc != 0 && m_cyc < m_lat));
    check("cyc doneE", 32'(doneE), 32'(m_cyc != 0 && m_cyc == m_lat));
    check("cyc resultE", resultE, exp_res);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Runs one op; leaves startE high in the DONE cycle
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_v, input int exp_lat, input bit b2b,
                       input bit perturb, input string name);
    int nbusy, done_at;
    if (b2b) begin
      step();
      check({name, " gap busyE"}, 32'(busyE), 32'd0);
      check({name, " gap doneE"}, 32'(doneE), 32'd0);
    end
    funct3E = f; SrcAE = a; SrcBE = b; startE = 1'b1;
    nbusy = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      step();
      if (busyE) nbusy++;
      if (doneE) done_at = i;
      else if (perturb) begin
        SrcAE = $urandom; SrcBE = $urandom; funct3E = 3'($urandom);
      end
    end
    check({name, " done cycle"}, 32'(done_at), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    check({name, " result"}, resultE, exp_v);
  endtask

  task automatic finish_op();
    startE = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          b2b;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [31:0] saved;

    #12;
    check("reset busyE", 32'(busyE), 32'd0);
    check("reset doneE", 32'(doneE), 32'd0);
    check("reset resultE", resultE, 32'd0);
    reset = 1'b0;
    step();

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 0, "mul");          finish_op();
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0, 0, "mulh"); finish_op();
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 0, "mulhu"); finish_op();
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 0, "mulhsu"); finish_op();

    do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0, "div by 0");             finish_op();
    do_op(3'd6, 32'd5, 32'd0, 32'd5, 1, 0, 0, "rem by 0");                     finish_op();
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0, "div ovf"); finish_op();
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, "rem ovf");      finish_op();

    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 0, "div");        finish_op();
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 0, "rem");        finish_op();
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 0, 0, "divu");                    finish_op();
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, 0, "remu");                     finish_op();

    // Flush in cycle 10 of a divide
    funct3E = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd3; startE = 1'b1;
    for (int i = 0; i < 10; i++) step();
    flushE = 1'b1; startE = 1'b0;
    step();
    flushE = 1'b0;
    check("flush busyE", 32'(busyE), 32'd0);
    check("flush doneE", 32'(doneE), 32'd0);
    check("flush resultE", resultE, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post flush doneE", 32'(doneE), 32'd0);
    end
    do_op(3'd0, 32'd6, 32'd7, 32'd42, 33, 0, 0, "mul after flush"); finish_op();

    // Async reset in cycle 20
    funct3E = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd3; startE = 1'b1;
    for (int i = 0; i < 20; i++) step();
    #2 reset = 1'b1;
    #1;
    check("async rst busyE", 32'(busyE), 32'd0);
    check("async rst doneE", 32'(doneE), 32'd0);
    check("async rst resultE", resultE, 32'd0);
    startE = 1'b0;
    #2 reset = 1'b0;
    step();

    // Back-to-back with operand perturbation during ITER
    do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0),
          33, 0, 1, "b2b mulhu");
    do_op(3'd4, 32'hDEAD_BEEF, 32'd17, ref_model(3'd4, 32'hDEAD_BEEF, 32'd17),
          33, 1, 1, "b2b div");
    do_op(3'd6, 32'd9, 32'd0, 32'd9, 1, 1, 1, "b2b rem0");
    finish_op();

    b2b = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      do_op(f, a, b, ref_model(f, a, b), is_special(f, a, b) ? 1 : 33, b2b,
            1'($urandom_range(0, 1)), "rand");
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) finish_op();
    end
    finish_op();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
